// File: rtl/mac_iter_sched_pkg.sv
// Shared types for the MAC iteration scheduler: FSM states, job config,
// scheduler flags and the streamer-side handshake bundles.
package mac_iter_sched_pkg;

  localparam int MAC_CNT_LEN   = 1024;
  localparam int MAC_NB_ITER_W = 16;
  localparam int MAC_ADDR_W    = 32;
  localparam int MAC_LEN_W     = $clog2(MAC_CNT_LEN) + 1;

  localparam int NUM_SRC = 3;  // a, b, c source streamers
  localparam int NUM_CH  = 4;  // a, b, c sources plus the d sink

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    COMPUTE   = 3'd2,
    WAIT      = 3'd3,
    UPDATEIDX = 3'd4,
    TERMINATE = 3'd5
  } state_fsm_t;

  // Job as programmed in the register file. Field widths follow the package
  // defaults, so the top-level parameters must stay at these values.
  typedef struct packed {
    logic [MAC_ADDR_W-1:0]    a_base;
    logic [MAC_ADDR_W-1:0]    b_base;
    logic [MAC_ADDR_W-1:0]    c_base;
    logic [MAC_ADDR_W-1:0]    d_base;
    logic [MAC_NB_ITER_W-1:0] nb_iter;
    logic [MAC_LEN_W-1:0]     len;
    logic [MAC_ADDR_W-1:0]    iter_stride;
    logic [MAC_ADDR_W-1:0]    one_stride;
    logic                     simple_mul;
    logic [4:0]               shift;
  } ctrl_sched_t;

  typedef struct packed {
    state_fsm_t               state;
    logic [MAC_NB_ITER_W-1:0] iter;
  } flags_sched_t;

  typedef struct packed {
    logic                  req_start;
    logic [MAC_ADDR_W-1:0] addr;
    logic [MAC_ADDR_W-1:0] trans_size;
  } fsm_ctrl_streamer_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_streamer_t;

  // The sink writes one word per pass for a scalar product, len words otherwise.
  function automatic logic [MAC_ADDR_W-1:0] sink_size(input logic simple_mul,
                                                      input logic [MAC_LEN_W-1:0] len);
    return simple_mul ? {{(MAC_ADDR_W-MAC_LEN_W){1'b0}}, len} : MAC_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mac_iter_sched_addr_gen.sv
// One address channel: loads its base at job start and advances by its
// stride once per completed pass (wraps modulo 2^ADDR_W).
module mac_iter_sched_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Clear beats load beats step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     addr_o <= '0;
    else if (clr_i)  addr_o <= '0;
    else if (load_i) addr_o <= base_i;
    else if (step_i) addr_o <= addr_o + stride_i;
  end

endmodule

// File: rtl/mac_iter_sched.sv
// Iteration scheduler for the MAC engine: runs nb_iter passes of
// start-streamers / compute / wait-sink / advance-addresses per job.
module mac_iter_sched
  import mac_iter_sched_pkg::*;
#(
  parameter int CNT_LEN   = MAC_CNT_LEN,
  parameter int NB_ITER_W = MAC_NB_ITER_W,
  parameter int ADDR_W    = MAC_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [ADDR_W-1:0]         a_base_i,
  input  logic [ADDR_W-1:0]         b_base_i,
  input  logic [ADDR_W-1:0]         c_base_i,
  input  logic [ADDR_W-1:0]         d_base_i,
  input  logic [NB_ITER_W-1:0]      nb_iter_i,
  input  logic [$clog2(CNT_LEN):0]  len_i,
  input  logic [ADDR_W-1:0]         iter_stride_i,
  input  logic [ADDR_W-1:0]         one_stride_i,
  input  logic                      simple_mul_i,
  input  logic [4:0]                shift_i,
  input  logic [2:0]                src_ready_start_i,
  input  logic [2:0]                src_done_i,
  input  logic                      sink_ready_start_i,
  input  logic                      sink_done_i,
  output logic [2:0]                src_req_start_o,
  output logic                      sink_req_start_o,
  output logic [ADDR_W-1:0]         a_addr_o,
  output logic [ADDR_W-1:0]         b_addr_o,
  output logic [ADDR_W-1:0]         c_addr_o,
  output logic [ADDR_W-1:0]         d_addr_o,
  output logic [ADDR_W-1:0]         src_trans_size_o,
  output logic [ADDR_W-1:0]         sink_trans_size_o,
  output logic                      eng_clear_o,
  output logic                      eng_enable_o,
  output logic                      eng_start_o,
  output logic                      eng_simple_mul_o,
  output logic [4:0]                eng_shift_o,
  output logic [$clog2(CNT_LEN):0]  eng_len_o,
  output logic                      busy_o,
  output logic                      done_o,
  output state_fsm_t                state_o
);

  localparam int LEN_W = $clog2(CNT_LEN) + 1;

  ctrl_sched_t                   cfg_d;
  flags_sched_t                  flags_q;
  logic [NB_ITER_W-1:0]          nb_iter_q;
  logic [LEN_W-1:0]              len_q;
  logic [ADDR_W-1:0]             iter_stride_q, one_stride_q, sink_size_q;
  logic                          simple_mul_q;
  logic [4:0]                    shift_q;
  logic [NUM_SRC-1:0]            src_mask_q;
  logic                          sink_seen_q;

  flags_streamer_t [NUM_SRC-1:0] src_flags;
  flags_streamer_t               sink_flags;
  fsm_ctrl_streamer_t            sink_ctrl;
  logic [NUM_SRC-1:0]            src_rdy, src_dn, src_mask_nxt;

  logic [NUM_CH-1:0][ADDR_W-1:0] ch_base, ch_stride, ch_addr;
  logic                          live, all_ready, fire, load, step;
  logic [NB_ITER_W-1:0]          iter_inc;

  assign cfg_d = '{a_base: a_base_i, b_base: b_base_i, c_base: c_base_i, d_base: d_base_i,
                   nb_iter: nb_iter_i, len: len_i, iter_stride: iter_stride_i,
                   one_stride: one_stride_i, simple_mul: simple_mul_i, shift: shift_i};

  genvar i;
  for (i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_flags[i] = '{ready_start: src_ready_start_i[i], done: src_done_i[i]};
    assign src_rdy[i]   = src_flags[i].ready_start;
    assign src_dn[i]    = src_flags[i].done;
  end
  assign sink_flags = '{ready_start: sink_ready_start_i, done: sink_done_i};

  // Strobes are combinational on the registered state so requests leave in
  // the same cycle the streamers report ready; reset and clear mute them.
  assign live         = rst_ni & ~clear_i;
  assign all_ready    = (&src_rdy) & sink_flags.ready_start;
  assign fire         = live & (flags_q.state == START) & all_ready;
  assign load         = live & (flags_q.state == IDLE) & start_i;
  assign step         = flags_q.state == UPDATEIDX;
  assign iter_inc     = flags_q.iter + 1'b1;
  assign src_mask_nxt = src_mask_q | src_dn;

  assign ch_base   = {cfg_d.d_base, cfg_d.c_base, cfg_d.b_base, cfg_d.a_base};
  assign ch_stride = {one_stride_q, iter_stride_q, iter_stride_q, iter_stride_q};

  for (i = 0; i < NUM_CH; i++) begin : g_addr
    mac_iter_sched_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clear_i),
      .load_i   (load),
      .step_i   (step),
      .base_i   (ch_base[i]),
      .stride_i (ch_stride[i]),
      .addr_o   (ch_addr[i])
    );
  end

  // Job sequencer: latches config, tracks pass progress and done masks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q       <= '0;
      nb_iter_q     <= '0;
      len_q         <= '0;
      iter_stride_q <= '0;
      one_stride_q  <= '0;
      sink_size_q   <= '0;
      simple_mul_q  <= 1'b0;
      shift_q       <= '0;
      src_mask_q    <= '0;
      sink_seen_q   <= 1'b0;
    end else if (clear_i) begin
      flags_q       <= '0;
      nb_iter_q     <= '0;
      len_q         <= '0;
      iter_stride_q <= '0;
      one_stride_q  <= '0;
      sink_size_q   <= '0;
      simple_mul_q  <= 1'b0;
      shift_q       <= '0;
      src_mask_q    <= '0;
      sink_seen_q   <= 1'b0;
    end else begin
      case (flags_q.state)
        IDLE: if (start_i) begin
          nb_iter_q     <= cfg_d.nb_iter;
          len_q         <= cfg_d.len;
          iter_stride_q <= cfg_d.iter_stride;
          one_stride_q  <= cfg_d.one_stride;
          simple_mul_q  <= cfg_d.simple_mul;
          shift_q       <= cfg_d.shift;
          sink_size_q   <= sink_size(cfg_d.simple_mul, cfg_d.len);
          flags_q.iter  <= '0;
          src_mask_q    <= '0;
          sink_seen_q   <= 1'b0;
          flags_q.state <= (cfg_d.nb_iter == '0 || cfg_d.len == '0) ? TERMINATE : START;
        end
        START: if (all_ready) flags_q.state <= COMPUTE;
        COMPUTE: begin
          src_mask_q <= src_mask_nxt;
          if (sink_flags.done) sink_seen_q <= 1'b1;
          if (&src_mask_nxt)   flags_q.state <= WAIT;
        end
        WAIT: if (sink_seen_q || sink_flags.done) flags_q.state <= UPDATEIDX;
        UPDATEIDX: begin
          flags_q.iter  <= iter_inc;
          src_mask_q    <= '0;
          sink_seen_q   <= 1'b0;
          flags_q.state <= (iter_inc == nb_iter_q) ? TERMINATE : START;
        end
        TERMINATE: flags_q.state <= IDLE;
        default:   flags_q.state <= IDLE;
      endcase
    end
  end

  assign sink_ctrl = '{req_start: fire, addr: ch_addr[3], trans_size: sink_size_q};

  assign src_req_start_o   = {NUM_SRC{fire}};
  assign sink_req_start_o  = sink_ctrl.req_start;
  assign a_addr_o          = ch_addr[0];
  assign b_addr_o          = ch_addr[1];
  assign c_addr_o          = ch_addr[2];
  assign d_addr_o          = sink_ctrl.addr;
  assign src_trans_size_o  = {{(ADDR_W-LEN_W){1'b0}}, len_q};
  assign sink_trans_size_o = sink_ctrl.trans_size;
  assign eng_clear_o       = load;
  assign eng_start_o       = fire;
  assign eng_enable_o      = (flags_q.state == COMPUTE) || (flags_q.state == WAIT);
  assign eng_simple_mul_o  = simple_mul_q;
  assign eng_shift_o       = shift_q;
  assign eng_len_o         = len_q;
  assign busy_o            = flags_q.state != IDLE;
  assign done_o            = flags_q.state == TERMINATE;
  assign state_o           = flags_q.state;

endmodule
